// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX packet arbiter.
// Provides the arbiter FSM state enum and the default idle timeout.
package uart_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int DEFAULT_TIMEOUT = 1023;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Single byte stream handshake bundle (data/valid/last/ready).
// master drives data/valid/last and samples ready; slave is the mirror.
interface uart_tx_arbiter_if #(
    parameter int DW = 8
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_out_reg.sv
// One-deep data/valid/last pipeline register with upstream-ready generation.
// Ports: clk, rst_n, up (slave side, accepts beats), dn (master side, presents beats).
module axis_out_reg #(
    parameter int DW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_tx_arbiter_if.slave   up,
    uart_tx_arbiter_if.master  dn
);

    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;

    // Register can take a new beat when empty or draining this cycle.
    assign up.tready = !valid_q || dn.tready;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (up.tvalid && up.tready) begin
            data_d  = up.tdata;
            last_d  = up.tlast;
            valid_d = 1'b1;
        end else if (dn.tready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign dn.tdata  = data_q;
    assign dn.tvalid = valid_q;
    assign dn.tlast  = last_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding one UART TX byte stream.
// Ports: clk, rst_n, s_t* (N_REQ requesters), m_t* (output), grant, abort_pulse.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N_REQ      = 2,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ*DATA_WIDTH-1:0] s_tdata,
    input  logic [N_REQ-1:0]            s_tvalid,
    input  logic [N_REQ-1:0]            s_tlast,
    output logic [N_REQ-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]       m_tdata,
    output logic                        m_tvalid,
    output logic                        m_tlast,
    input  logic                        m_tready,
    output logic [N_REQ-1:0]            grant,
    output logic                        abort_pulse
);

    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [OW-1:0]    last_q, last_d;
    logic [CW-1:0]    tcnt_q, tcnt_d;
    logic             abort_q, abort_d;
    logic             arm_q;

    logic [DATA_WIDTH-1:0] lane [N_REQ];
    logic                  own_valid, own_last, accept;
    logic                  pick_found;
    logic [OW-1:0]         pick_idx, cand;

    uart_tx_arbiter_if #(.DW(DATA_WIDTH)) up_if ();
    uart_tx_arbiter_if #(.DW(DATA_WIDTH)) dn_if ();

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        assign lane[i] = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign own_valid = s_tvalid[owner_q];
    assign own_last  = s_tlast[owner_q];
    assign accept    = (state_q == ARB_BUSY) && own_valid && up_if.tready;

    // Round-robin search starting just after the previous owner.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = OW'((int'(last_q) + k) % N_REQ);
            if (!pick_found && s_tvalid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= OW'(N_REQ - 1);
            tcnt_q  <= '0;
            abort_q <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            tcnt_q  <= tcnt_d;
            abort_q <= abort_d;
            arm_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        tcnt_d  = tcnt_q;
        abort_d = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                tcnt_d = '0;
                // arm_q holds off arbitration for the first cycle after reset.
                if (arm_q && pick_found) begin
                    state_d = ARB_BUSY;
                    grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    owner_d = pick_idx;
                end
            end
            ARB_BUSY: begin
                if (accept) begin
                    tcnt_d = '0;
                    if (own_last) begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                        last_d  = owner_q;
                    end
                end else if (!own_valid) begin
                    if (tcnt_q != CW'(TIMEOUT))
                        tcnt_d = tcnt_q + 1'b1;
                    // Release when this idle cycle brings the count to TIMEOUT.
                    if (tcnt_q >= CW'(TIMEOUT - 1)) begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                        last_d  = owner_q;
                        abort_d = 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        up_if.tvalid = (state_q == ARB_BUSY) && own_valid;
        up_if.tdata  = lane[owner_q];
        up_if.tlast  = own_last;
        s_tready     = '0;
        if (state_q == ARB_BUSY)
            s_tready = grant_q & {N_REQ{up_if.tready}};
    end

    axis_out_reg #(.DW(DATA_WIDTH)) u_out (
        .clk   (clk),
        .rst_n (rst_n),
        .up    (up_if.slave),
        .dn    (dn_if.master)
    );

    assign dn_if.tready = m_tready;
    assign m_tdata      = dn_if.tdata;
    assign m_tvalid     = dn_if.tvalid;
    assign m_tlast      = dn_if.tlast;
    assign grant        = grant_q;
    assign abort_pulse  = abort_q;

endmodule
